mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's data/instruction port: it accepts one read or write request at a time over a valid/ready handshake and serves it from an internal word array after a programmable number of wait cycles. Byte, halfword and word accesses are supported with lane selection. The block replaces the fixed-latency memory when the control unit runs in stall-on-memory mode. The CPU (via IorD address, SS store data and MDR capture) is the initiator; this block is the responder.

---
 rtl/mem_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder for the multicycle CPU data/instruction
//            port. Accepts one request at a time on a valid/ready handshake
//            and serves it from an internal word array after LATENCY wait
//            cycles. Supports byte, halfword and word accesses with lane
//            selection; out-of-range and illegal-size requests answer with an
//            error and never touch the array.
// Ports    : clock       - rising-edge clock
//            reset       - synchronous, active-low reset
//            req_valid   - request present
//            req_ready   - responder idle and able to accept
//            req_write   - 1 = store, 0 = load
//            req_size    - 00 word, 01 halfword, 10 byte, 11 illegal
//            req_addr    - byte address
//            req_wdata   - right-aligned store data
//            resp_valid  - one-cycle response pulse
//            resp_rdata  - zero-extended, right-aligned load data
//            resp_err    - request was rejected (qualified by resp_valid)
//            busy        - request in flight (WAIT or RESP)
// Config   : MEM_RESP_ALIGN_CHECK_EN - when defined, misaligned halfword and
//            word accesses return an error instead of ignoring low addr bits.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int          c_IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] c_LIMIT    = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [2:0]  c_CNT_INIT = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t       r_state;
    logic [2:0]   r_cnt;
    logic         r_write;
    logic [1:0]   r_size;
    logic [31:0]  r_addr;
    logic [31:0]  r_wdata;
    logic         r_resp_valid;
    logic         r_resp_err;
    logic [31:0]  r_resp_rdata;

    // Contents are deliberately not reset.
    logic [31:0]  r_mem [DEPTH_WORDS];

    logic [c_IDX_W-1:0] w_idx;
    logic               w_misalign;
    logic               w_err;
    logic               w_access;
    logic [31:0]        w_old;
    logic [31:0]        w_rd;
    logic [31:0]        w_new;

    assign w_idx = r_addr[c_IDX_W+1:2];

`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign w_misalign = ((r_size == 2'b01) && r_addr[0]) ||
                        ((r_size == 2'b00) && (r_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err    = (r_size == 2'b11) || ({1'b0, r_addr} >= c_LIMIT) || w_misalign;
    // The access happens on the last WAIT edge; reset at that edge suppresses it.
    assign w_access = (r_state == S_WAIT) && (r_cnt == 3'd0);

    // Lane extraction for loads and lane merge for stores. Low address bits
    // below the access size are ignored here; alignment errors, if enabled,
    // are handled by w_err.
    always_comb begin
        w_old = r_mem[w_idx];
        w_rd  = 32'h0;
        w_new = w_old;
        case (r_size)
            2'b00: begin
                w_rd  = w_old;
                w_new = r_wdata;
            end
            2'b01: begin
                if (r_addr[1]) begin
                    w_rd          = {16'h0, w_old[31:16]};
                    w_new[31:16]  = r_wdata[15:0];
                end else begin
                    w_rd          = {16'h0, w_old[15:0]};
                    w_new[15:0]   = r_wdata[15:0];
                end
            end
            2'b10: begin
                w_rd                              = {24'h0, w_old[{r_addr[1:0], 3'b000} +: 8]};
                w_new[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset && w_access && r_write && !w_err) begin
            r_mem[w_idx] <= w_new;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (req_valid) begin
                        r_write <= req_write;
                        r_size  <= req_size;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= c_CNT_INIT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_err;
                        r_resp_rdata <= (w_err || r_write) ? 32'h0 : w_rd;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state == S_WAIT) || (r_state == S_RESP);
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder (DEPTH_WORDS=64,
//            LATENCY=2). Table of request/expected-response records plus
//            hand-written sequences for handshake timing and reset abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int total;
    int bad;

    logic [32:0] exp_q[$];

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    mem_responder #(
        .DEPTH_WORDS(64),
        .LATENCY    (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard side: every response pulse pops one expectation.
    always @(negedge clock) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got rdata=%h err=%b expected no response", resp_rdata, resp_err);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("resp_err", {31'h0, resp_err}, {31'h0, e[32]});
                chk("resp_rdata", resp_rdata, e[31:0]);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 once the response was consumed.
    task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input logic e_err, input logic [31:0] e_rd);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clock); #1; n++;
        end
        if (req_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got req_ready=%b expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = d;
        exp_q.push_back({e_err, e_rd});
        @(posedge clock); #1;
        req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clock); #1; n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got %0d pending responses expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'b00;
        req_addr  = 32'h0;
        req_wdata = 32'h0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);

        // Reset coinciding with a request: the request must not be accepted.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h0BAD0BAD;
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        chk("rst_vs_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_vs_req_busy", {31'h0, busy}, 32'h0);

        // Handshake timing of the first store (LATENCY = 2).
        @(posedge clock); #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h10;
        req_wdata = 32'hDEADBEEF;
        exp_q.push_back({1'b0, 32'h0});
        @(posedge clock); #1;           // E0
        req_valid = 1'b0;
        chk("e0_req_ready", {31'h0, req_ready}, 32'h0);
        chk("e0_busy", {31'h0, busy}, 32'h1);
        @(posedge clock); #1;           // E0+1
        chk("e1_resp_valid", {31'h0, resp_valid}, 32'h0);
        @(posedge clock); #1;           // E0+2
        chk("e2_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("e2_resp_err", {31'h0, resp_err}, 32'h0);
        @(posedge clock); #1;           // E0+3
        chk("e3_req_ready", {31'h0, req_ready}, 32'h1);
        chk("e3_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("e3_pending", exp_q.size(), 32'h0);

        // w, size, addr, wdata, err, rdata
        vecs.push_back('{1'b0, 2'b00, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 2'b10, 32'h13,  32'h0,        1'b0, 32'h000000DE});
        vecs.push_back('{1'b0, 2'b01, 32'h12,  32'h0,        1'b0, 32'h0000DEAD});
        vecs.push_back('{1'b1, 2'b10, 32'h11,  32'h55,       1'b0, 32'h0});
        vecs.push_back('{1'b0, 2'b00, 32'h10,  32'h0,        1'b0, 32'hDEAD55EF});
        vecs.push_back('{1'b0, 2'b00, 32'h100, 32'h0,        1'b1, 32'h0});
        vecs.push_back('{1'b0, 2'b11, 32'h10,  32'h0,        1'b1, 32'h0});
        vecs.push_back('{1'b1, 2'b11, 32'h10,  32'hFFFFFFFF, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 2'b00, 32'h100, 32'hFFFFFFFF, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 2'b00, 32'h10,  32'h0,        1'b0, 32'hDEAD55EF});
        vecs.push_back('{1'b1, 2'b00, 32'h14,  32'h11223344, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 2'b01, 32'h16,  32'h0000CAFE, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 2'b00, 32'h14,  32'h0,        1'b0, 32'hCAFE3344});
        vecs.push_back('{1'b0, 2'b10, 32'h14,  32'h0,        1'b0, 32'h00000044});
        vecs.push_back('{1'b1, 2'b00, 32'hFC,  32'h01020304, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 2'b10, 32'hFF,  32'h0,        1'b0, 32'h00000001});
`ifdef MEM_RESP_ALIGN_CHECK_EN
        vecs.push_back('{1'b0, 2'b01, 32'h11,  32'h0,        1'b1, 32'h0});
        vecs.push_back('{1'b0, 2'b00, 32'h12,  32'h0,        1'b1, 32'h0});
`else
        vecs.push_back('{1'b0, 2'b01, 32'h11,  32'h0,        1'b0, 32'h000055EF});
        vecs.push_back('{1'b0, 2'b00, 32'h12,  32'h0,        1'b0, 32'hDEAD55EF});
`endif
        vecs.push_back('{1'b1, 2'b00, 32'h20,  32'h12345678, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 2'b00, 32'h10,  32'h0,        1'b0, 32'hDEAD55EF});

        foreach (vecs[i]) begin
            issue(vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].d, vecs[i].err, vecs[i].rd);
        end

        // Store aborted by reset: resp_rdata is nonzero from the last load,
        // so a return to reset values is observable.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h20;
        req_wdata = 32'h99999999;
        @(posedge clock); #1;           // E0
        req_valid = 1'b0;
        @(posedge clock); #1;           // E0+1
        reset = 1'b0;
        @(posedge clock); #1;           // E0+2
        chk("abort_req_ready", {31'h0, req_ready}, 32'h1);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("abort_resp_err", {31'h0, resp_err}, 32'h0);
        chk("abort_resp_rdata", resp_rdata, 32'h0);
        reset = 1'b1;
        @(posedge clock); #1;
        issue(1'b0, 2'b00, 32'h20, 32'h0, 1'b0, 32'h12345678);

        repeat (3) @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
